// File: rtl/link_buf_ctrl_pkg.sv
// Shared constants for the link-id interleaver buffer controller: state encoding,
// the link table (m_len -> base/id) and default bus widths.
package link_buf_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 13;
    localparam int N_LINKS    = 6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_TURN  = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Regions are packed back to back; each region length equals its m_len.
    localparam logic [DEF_LEN_W-1:0] LINK_LEN [N_LINKS] = '{
        13'd288, 13'd672, 13'd1056, 13'd432, 13'd1872, 13'd5616
    };
    localparam logic [DEF_ADDR_W-1:0] LINK_BASE [N_LINKS] = '{
        16'h0000, 16'h0120, 16'h03C0, 16'h07E0, 16'h0990, 16'h10E0
    };
    localparam logic [4:0] LINK_ID [N_LINKS] = '{
        5'd5, 5'd6, 5'd7, 5'd11, 5'd17, 5'd19
    };

endpackage

// File: rtl/link_buf_ctrl_if.sv
// RAM-side bus of the link buffer controller: address, strobes and read-valid.
interface link_buf_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wen;
    logic              ram_ren;
    logic              rd_vld;

    modport master (output ram_addr, ram_wen, ram_ren, rd_vld);
    modport slave  (input  ram_addr, ram_wen, ram_ren, rd_vld);
endinterface

// File: rtl/link_buf_ctrl_lut.sv
// Combinational link table decode: m_len -> {hit, base, id}.
module link_lut
    import link_buf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic [LEN_W-1:0]  m_len,
    output logic              hit,
    output logic [ADDR_W-1:0] base,
    output logic [4:0]        id
);

    logic [N_LINKS-1:0] match;

    genvar gi;
    generate
        for (gi = 0; gi < N_LINKS; gi++) begin : g_match
            assign match[gi] = (m_len == LEN_W'(LINK_LEN[gi]));
        end
    endgenerate

    // Table lengths are distinct, so at most one match bit is set and OR-ing is safe.
    always_comb begin
        hit  = |match;
        base = '0;
        id   = '0;
        for (int i = 0; i < N_LINKS; i++) begin
            if (match[i]) begin
                base = base | ADDR_W'(LINK_BASE[i]);
                id   = id | LINK_ID[i];
            end
        end
    end

endmodule

// File: rtl/link_buf_ctrl.sv
// Frame sequencer for the shared single-port interleaver RAM: one write phase,
// a turnaround cycle, one read phase, then a done pulse.
module link_buf_ctrl
    import link_buf_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic [LEN_W-1:0] m_len,
    input  logic             abort,
    input  logic             din_vld,
    input  logic             rd_req,
    link_buf_ctrl_if.master  ram,
    output logic [4:0]       link_id,
    output logic             busy,
    output logic             done,
    output logic             err_len,
    output logic             ovf
);

    state_t            state_reg;
    logic [LEN_W-1:0]  wcnt_reg, rcnt_reg, len_reg;
    logic [LEN_W-1:0]  wcnt_next, rcnt_next;
    logic [ADDR_W-1:0] base_reg, addr_reg;
    logic [4:0]        id_reg;
    logic              wen_reg, ren_reg, done_reg, err_reg, ovf_reg;
    logic [RD_LAT-1:0] vld_pipe;

    logic              lut_hit;
    logic [ADDR_W-1:0] lut_base;
    logic [4:0]        lut_id;

    link_lut #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_lut (
        .m_len (m_len),
        .hit   (lut_hit),
        .base  (lut_base),
        .id    (lut_id)
    );

    assign wcnt_next = wcnt_reg + LEN_W'(1);
    assign rcnt_next = rcnt_reg + LEN_W'(1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= ST_IDLE;
            wcnt_reg  <= '0;
            rcnt_reg  <= '0;
            len_reg   <= '0;
            base_reg  <= '0;
            addr_reg  <= '0;
            id_reg    <= '0;
            wen_reg   <= 1'b0;
            ren_reg   <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            wen_reg  <= 1'b0;
            ren_reg  <= 1'b0;
            done_reg <= 1'b0;
            err_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
            if (abort && state_reg != ST_IDLE) begin
                state_reg <= ST_IDLE;
                wcnt_reg  <= '0;
                rcnt_reg  <= '0;
                id_reg    <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        // abort in the same cycle drops the start entirely
                        if (start && !abort) begin
                            if (lut_hit) begin
                                base_reg  <= lut_base;
                                len_reg   <= m_len;
                                id_reg    <= lut_id;
                                state_reg <= ST_WRITE;
                            end else begin
                                err_reg <= 1'b1;
                            end
                        end
                    end
                    ST_WRITE: begin
                        if (din_vld) begin
                            wen_reg  <= 1'b1;
                            addr_reg <= base_reg + ADDR_W'(wcnt_reg);
                            wcnt_reg <= wcnt_next;
                            if (wcnt_next == len_reg) begin
                                state_reg <= ST_TURN;
                            end
                        end
                    end
                    ST_TURN: begin
                        ovf_reg   <= din_vld;
                        state_reg <= ST_READ;
                    end
                    ST_READ: begin
                        ovf_reg <= din_vld;
                        if (rd_req) begin
                            ren_reg  <= 1'b1;
                            addr_reg <= base_reg + ADDR_W'(rcnt_reg);
                            rcnt_reg <= rcnt_next;
                            if (rcnt_next == len_reg) begin
                                state_reg <= ST_DONE;
                                done_reg  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        ovf_reg   <= din_vld;
                        wcnt_reg  <= '0;
                        rcnt_reg  <= '0;
                        id_reg    <= '0;
                        state_reg <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Read-valid pipe tracks issued reads only, so abort does not cancel them.
    genvar gi;
    generate
        for (gi = 0; gi < RD_LAT; gi++) begin : g_pipe
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) vld_pipe[0] <= 1'b0;
                    else        vld_pipe[0] <= ren_reg;
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge n_rst) begin
                    if (!n_rst) vld_pipe[gi] <= 1'b0;
                    else        vld_pipe[gi] <= vld_pipe[gi-1];
                end
            end
        end
    endgenerate

    assign ram.ram_addr = addr_reg;
    assign ram.ram_wen  = wen_reg;
    assign ram.ram_ren  = ren_reg;
    assign ram.rd_vld   = vld_pipe[RD_LAT-1];

    assign link_id = id_reg;
    assign busy    = (state_reg != ST_IDLE);
    assign done    = done_reg;
    assign err_len = err_reg;
    assign ovf     = ovf_reg;

endmodule

// File: tb/tb_link_buf_ctrl.sv
// Self-checking bench for link_buf_ctrl: per-cycle comparison against a
// frame-level model, a table of link decodes and hand-written corner sequences.
module tb_link_buf_ctrl;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        din_vld = 1'b0;
    logic        rd_req = 1'b0;
    logic [12:0] m_len = '0;
    logic [4:0]  link_id;
    logic        busy, done, err_len, ovf;

    link_buf_ctrl_if #(.ADDR_W(16)) ram_bus ();

    link_buf_ctrl #(
        .ADDR_W (16),
        .LEN_W  (13),
        .RD_LAT (1)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .m_len   (m_len),
        .abort   (abort),
        .din_vld (din_vld),
        .rd_req  (rd_req),
        .ram     (ram_bus),
        .link_id (link_id),
        .busy    (busy),
        .done    (done),
        .err_len (err_len),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int tbl_len  [6] = '{288, 672, 1056, 432, 1872, 5616};
    int tbl_base [6] = '{'h0000, 'h0120, 'h03C0, 'h07E0, 'h0990, 'h10E0};
    int tbl_id   [6] = '{5, 6, 7, 11, 17, 19};

    // Frame-level model: progress is tracked as write/read counts of the active frame.
    bit          m_act, m_gap;
    int          m_wr, m_rd, m_flen;
    logic [15:0] m_base, m_addr;
    logic [4:0]  m_id;
    bit          m_wen, m_ren, m_rdv, m_done, m_err, m_ovf;

    // Observations of the DUT bus, per sequence.
    int          cnt_w, cnt_r, cnt_v, cnt_d;
    logic [15:0] first_w, last_w;
    logic [15:0] wq [$];

    typedef struct {
        logic [12:0] len;
        bit          hit;
        logic [15:0] base;
        logic [4:0]  id;
    } lut_vec_t;
    lut_vec_t vecs [10];

    function automatic int find_link(input int len);
        for (int i = 0; i < 6; i++) if (tbl_len[i] == len) return i;
        return -1;
    endfunction

    function automatic logic [31:0] dut_vec();
        return {4'b0, ram_bus.ram_addr, ram_bus.ram_wen, ram_bus.ram_ren, ram_bus.rd_vld,
                link_id, busy, done, err_len, ovf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_gap = 0; m_wr = 0; m_rd = 0; m_flen = 0;
        m_base = '0; m_addr = '0; m_id = '0;
        m_wen = 0; m_ren = 0; m_rdv = 0; m_done = 0; m_err = 0; m_ovf = 0;
    endtask

    task automatic obs_clear();
        cnt_w = 0; cnt_r = 0; cnt_v = 0; cnt_d = 0;
        first_w = '0; last_w = '0;
        wq.delete();
    endtask

    task automatic zero_inputs();
        start = 0; abort = 0; din_vld = 0; rd_req = 0;
    endtask

    // Apply current inputs for one clock, predict the next-cycle outputs, compare.
    task automatic tick();
        int k;
        bit nw, nr, nd, ne, no;
        logic [31:0] exp_v;
        nw = 0; nr = 0; nd = 0; ne = 0; no = 0;
        m_rdv = m_ren;
        if (!m_act) begin
            if (start && !abort) begin
                k = find_link(int'(m_len));
                if (k < 0) ne = 1;
                else begin
                    m_act = 1; m_gap = 0; m_wr = 0; m_rd = 0;
                    m_flen = tbl_len[k]; m_base = 16'(tbl_base[k]); m_id = 5'(tbl_id[k]);
                end
            end
        end else if (abort) begin
            m_act = 0;
        end else if (m_wr < m_flen) begin
            if (din_vld) begin
                nw = 1; m_addr = m_base + 16'(m_wr); m_wr++;
                if (m_wr == m_flen) m_gap = 1;
            end
        end else if (m_gap) begin
            no = din_vld; m_gap = 0;
        end else if (m_rd < m_flen) begin
            no = din_vld;
            if (rd_req) begin
                nr = 1; m_addr = m_base + 16'(m_rd); m_rd++;
                if (m_rd == m_flen) nd = 1;
            end
        end else begin
            no = din_vld; m_act = 0;
        end
        m_wen = nw; m_ren = nr; m_done = nd; m_err = ne; m_ovf = no;
        @(posedge clk);
        #1;
        exp_v = {4'b0, m_addr, m_wen, m_ren, m_rdv, (m_act ? m_id : 5'd0),
                 m_act, m_done, m_err, m_ovf};
        chk("cycle", dut_vec(), exp_v);
        if (ram_bus.ram_wen) begin
            if (cnt_w == 0) first_w = ram_bus.ram_addr;
            last_w = ram_bus.ram_addr;
            cnt_w++;
            wq.push_back(ram_bus.ram_addr);
        end
        if (ram_bus.ram_ren) begin
            cnt_r++;
            if (wq.size() > 0) chk("rd_addr", 32'(ram_bus.ram_addr), 32'(wq.pop_front()));
            else chk("rd_addr_queue", wq.size(), 1);
        end
        if (ram_bus.rd_vld) cnt_v++;
        if (done) cnt_d++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        int k;

        vecs[0] = '{13'd288,  1, 16'h0000, 5'd5};
        vecs[1] = '{13'd672,  1, 16'h0120, 5'd6};
        vecs[2] = '{13'd1056, 1, 16'h03C0, 5'd7};
        vecs[3] = '{13'd432,  1, 16'h07E0, 5'd11};
        vecs[4] = '{13'd1872, 1, 16'h0990, 5'd17};
        vecs[5] = '{13'd5616, 1, 16'h10E0, 5'd19};
        vecs[6] = '{13'd100,  0, 16'h0000, 5'd0};
        vecs[7] = '{13'd0,    0, 16'h0000, 5'd0};
        vecs[8] = '{13'd287,  0, 16'h0000, 5'd0};
        vecs[9] = '{13'd8191, 0, 16'h0000, 5'd0};

        model_reset();
        obs_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", dut_vec(), 32'h0);
        n_rst = 1;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_link_id", link_id, 0);
        $display("reset sequence checked");

        // Link table decode
        for (int v = 0; v < 10; v++) begin
            zero_inputs();
            start = 1; m_len = vecs[v].len;
            tick();
            start = 0;
            chk("lut_err_len", err_len, !vecs[v].hit);
            chk("lut_busy", busy, vecs[v].hit);
            chk("lut_link_id", link_id, vecs[v].id);
            if (vecs[v].hit) begin
                din_vld = 1;
                tick();
                din_vld = 0;
                chk("lut_first_addr", ram_bus.ram_addr, vecs[v].base);
                chk("lut_first_wen", ram_bus.ram_wen, 1);
                abort = 1;
                tick();
                abort = 0;
                chk("lut_abort_idle", busy, 0);
            end else begin
                tick();
                chk("lut_miss_strobes", {ram_bus.ram_wen, ram_bus.ram_ren, err_len, busy}, 0);
            end
            $display("lut vector m_len=%0d link_id=%0d", vecs[v].len, vecs[v].id);
        end

        // Simultaneous abort and start in IDLE: start dropped
        start = 1; abort = 1; m_len = 13'd288;
        tick();
        zero_inputs();
        chk("abort_start_busy", busy, 0);
        chk("abort_start_err", err_len, 0);
        $display("abort+start in idle checked");

        // Link 5: full back-to-back frame
        obs_clear();
        start = 1; m_len = 13'd288;
        tick();
        start = 0;
        chk("l5_link_id", link_id, 5);
        din_vld = 1;
        repeat (288) tick();
        din_vld = 0;
        tick();
        rd_req = 1;
        repeat (288) tick();
        rd_req = 0;
        repeat (2) tick();
        chk("l5_writes", cnt_w, 288);
        chk("l5_first_addr", first_w, 16'h0000);
        chk("l5_last_addr", last_w, 16'h011F);
        chk("l5_reads", cnt_r, 288);
        chk("l5_rd_vld", cnt_v, 288);
        chk("l5_done", cnt_d, 1);
        chk("l5_idle", busy, 0);
        $display("link 5 frame: writes=%0d reads=%0d done=%0d", cnt_w, cnt_r, cnt_d);

        // Link 19 with random gaps and stray inputs
        obs_clear();
        start = 1; m_len = 13'd5616;
        tick();
        start = 0;
        chk("l19_link_id", link_id, 19);
        guard = 0;
        while (m_wr < 5616 && guard < 20000) begin
            din_vld = 1'($urandom_range(0, 1));
            rd_req  = ($urandom_range(0, 3) == 0);
            start   = ($urandom_range(0, 15) == 0);
            m_len   = 13'd288;
            tick();
            guard++;
        end
        chk("l19_write_bound", guard < 20000, 1);
        zero_inputs();
        chk("l19_no_early_read", cnt_r, 0);
        guard = 0;
        while (m_act && guard < 20000) begin
            rd_req  = 1'($urandom_range(0, 1));
            din_vld = ($urandom_range(0, 7) == 0);
            tick();
            guard++;
        end
        chk("l19_read_bound", guard < 20000, 1);
        zero_inputs();
        tick();
        chk("l19_writes", cnt_w, 5616);
        chk("l19_last_addr", last_w, 16'h26CF);
        chk("l19_reads", cnt_r, 5616);
        chk("l19_done", cnt_d, 1);
        $display("link 19 frame: writes=%0d last=%h done=%0d", cnt_w, last_w, cnt_d);

        // Link 7: stray start/rd_req during write, then abort after 10 writes
        obs_clear();
        start = 1; m_len = 13'd1056;
        tick();
        zero_inputs();
        for (int i = 0; i < 10; i++) begin
            din_vld = 1;
            if (i == 4) begin start = 1; m_len = 13'd288; rd_req = 1; end
            tick();
            start = 0; rd_req = 0;
        end
        din_vld = 0;
        chk("l7_link_id", link_id, 7);
        chk("l7_no_ren", cnt_r, 0);
        abort = 1;
        tick();
        abort = 0;
        chk("l7_abort_busy", busy, 0);
        chk("l7_abort_strobes", {ram_bus.ram_wen, ram_bus.ram_ren, link_id}, 0);
        tick();
        chk("l7_abort_no_done", cnt_d, 0);
        chk("l7_abort_writes", cnt_w, 10);
        obs_clear();
        start = 1; m_len = 13'd1056;
        tick();
        start = 0;
        din_vld = 1;
        tick();
        chk("l7_restart_addr", ram_bus.ram_addr, 16'h03C0);
        repeat (1055) tick();
        din_vld = 0;
        tick();
        rd_req = 1;
        repeat (3) tick();
        rd_req = 0;
        din_vld = 1;
        tick();
        din_vld = 0;
        chk("l7_read_ovf", ovf, 1);
        chk("l7_read_ovf_addr", ram_bus.ram_addr, 16'h03C2);
        chk("l7_read_ovf_noren", ram_bus.ram_ren, 0);
        rd_req = 1;
        repeat (1053) tick();
        rd_req = 0;
        repeat (2) tick();
        chk("l7_done", cnt_d, 1);
        chk("l7_reads", cnt_r, 1056);
        $display("link 7 abort/restart frame: writes=%0d reads=%0d", cnt_w, cnt_r);

        // Random short frames with random abort and stray inputs
        for (int f = 0; f < 6; f++) begin
            int lens [4] = '{288, 432, 672, 100};
            obs_clear();
            k = $urandom_range(0, 3);
            start = 1; m_len = 13'(lens[k]);
            tick();
            start = 0;
            guard = 0;
            while (m_act && guard < 5000) begin
                din_vld = ($urandom_range(0, 9) < 7);
                rd_req  = ($urandom_range(0, 9) < 7);
                abort   = ($urandom_range(0, 299) == 0);
                start   = ($urandom_range(0, 31) == 0);
                m_len   = 13'(tbl_len[$urandom_range(0, 5)]);
                tick();
                guard++;
            end
            zero_inputs();
            tick();
            chk("rand_bound", guard < 5000, 1);
            $display("random frame %0d m_len=%0d writes=%0d reads=%0d done=%0d",
                     f, lens[k], cnt_w, cnt_r, cnt_d);
        end

        // Asynchronous reset mid-frame
        obs_clear();
        start = 1; m_len = 13'd672;
        tick();
        start = 0;
        din_vld = 1;
        repeat (20) tick();
        din_vld = 0;
        #3;
        n_rst = 0;
        #1;
        chk("async_reset", dut_vec(), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1;
        tick();
        chk("async_reset_idle", busy, 0);
        start = 1; m_len = 13'd288;
        tick();
        start = 0;
        din_vld = 1;
        tick();
        din_vld = 0;
        chk("async_reset_restart", ram_bus.ram_addr, 16'h0000);
        abort = 1;
        tick();
        abort = 0;
        tick();
        $display("async reset mid-frame checked");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
